// File: rtl/servo_gait_seq_if.sv
// servo_gait_seq_if: control, keyframe-write and pulse-length signals of the gait sequencer.
interface servo_gait_seq_if #(
    parameter int NCH  = 3,
    parameter int NKF  = 4,
    parameter int PW_W = 16
);
    localparam int KW = $clog2(NKF);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    logic                  start;
    logic                  stop;
    logic                  hold;
    logic                  loop_en;
    logic                  kf_wr_en;
    logic [KW-1:0]         kf_wr_idx;
    logic [CW-1:0]         kf_wr_ch;
    logic [PW_W-1:0]       kf_wr_data;
    logic [NCH*PW_W-1:0]   pul_len;
    logic                  running;
    logic [KW-1:0]         seg_idx;
    logic                  done;
    logic [NCH-1:0]        servo_en;
    modport master (
        output start, stop, hold, loop_en, kf_wr_en, kf_wr_idx, kf_wr_ch, kf_wr_data,
        input  pul_len, running, seg_idx, done, servo_en
    );
    modport slave (
        input  start, stop, hold, loop_en, kf_wr_en, kf_wr_idx, kf_wr_ch, kf_wr_data,
        output pul_len, running, seg_idx, done, servo_en
    );
endinterface

// File: rtl/servo_gait_seq.sv
// servo_gait_seq: keyframe table with per-tick linear interpolation and clamping of servo pulse lengths.
module servo_gait_seq #(
    parameter int NCH        = 3,
    parameter int NKF        = 4,
    parameter int PW_W       = 16,
    parameter int TICK_DIV   = 500000,
    parameter int STEP_SHIFT = 5,
    parameter int PW_MIN     = 500,
    parameter int PW_MAX     = 2500,
    parameter int PW_NEUTRAL = 1500
) (
    input  logic             CLK,
    input  logic             rst,
    servo_gait_seq_if.slave  bus
);
    localparam int KW  = $clog2(NKF);
    localparam int PSW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int PW  = PW_W + STEP_SHIFT + 2;
    localparam logic signed [PW-1:0] LO = PW'(PW_MIN);
    localparam logic signed [PW-1:0] HI = PW'(PW_MAX);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t state, state_d;

    logic [PSW-1:0]        presc;
    logic [KW-1:0]         k, nk;
    logic [STEP_SHIFT-1:0] step;
    logic [PW_W-1:0]       kf [NKF][NCH];
    logic signed [PW-1:0]  base [NCH];
    logic signed [PW-1:0]  df [NCH];
    logic signed [PW-1:0]  iv [NCH];
    logic [PW_W-1:0]       cval [NCH];
    logic                  run_ok, tick, fin;
    logic [NCH*PW_W-1:0]   pul_len;
    logic                  done;
    logic [NCH-1:0]        servo_en;

    assign nk = (k == KW'(NKF-1)) ? '0 : k + 1'b1;

    always_ff @(posedge CLK) begin
        state <= rst ? IDLE : state_d;
    end

    // start/stop pulses pre-empt counting in the cycle they arrive
    always_comb begin
        run_ok  = state != IDLE && !bus.hold && !bus.stop && !bus.start;
        tick    = run_ok && presc == PSW'(TICK_DIV-1);
        fin     = tick && k == KW'(NKF-1) && step == '0 && !bus.loop_en;
        state_d = bus.stop ? IDLE : bus.start ? RUN : state == IDLE ? IDLE :
                  fin ? IDLE : bus.hold ? HOLD : RUN;
    end

    // floor-rounded interpolation via arithmetic shift, then clamp
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            base[c] = PW'(kf[k][c]);
            df[c]   = $signed(PW'(kf[nk][c])) - base[c];
            iv[c]   = base[c] + ((df[c] * $signed(PW'(step))) >>> STEP_SHIFT);
            cval[c] = iv[c] < LO ? PW_W'(PW_MIN) : iv[c] > HI ? PW_W'(PW_MAX) : iv[c][PW_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            presc    <= '0;
            k        <= '0;
            step     <= '0;
            done     <= 1'b0;
            servo_en <= '0;
            for (int c = 0; c < NCH; c++) pul_len[c*PW_W +: PW_W] <= PW_W'(PW_NEUTRAL);
            for (int i = 0; i < NKF; i++)
                for (int c = 0; c < NCH; c++) kf[i][c] <= PW_W'(PW_NEUTRAL);
        end else begin
            done <= fin;
            if (bus.kf_wr_en && 32'(bus.kf_wr_idx) < NKF && 32'(bus.kf_wr_ch) < NCH)
                kf[bus.kf_wr_idx][bus.kf_wr_ch] <= bus.kf_wr_data;
            if (bus.start && !bus.stop) begin
                presc    <= '0;
                k        <= '0;
                step     <= '0;
                servo_en <= '1;
            end else if (run_ok) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    for (int c = 0; c < NCH; c++) pul_len[c*PW_W +: PW_W] <= cval[c];
                    if (!fin) begin
                        step <= step + 1'b1;
                        if (step == '1) k <= nk;
                    end
                end
            end
        end
    end

    assign bus.pul_len  = pul_len;
    assign bus.running  = state != IDLE;
    assign bus.seg_idx  = k;
    assign bus.done     = done;
    assign bus.servo_en = servo_en;
endmodule

// File: tb/tb_servo_gait_seq.sv
// tb_servo_gait_seq: directed plus random stimulus, position-based reference model and per-cycle scoreboard.
module tb_servo_gait_seq;
    localparam int NCH = 3, NKF = 4, PW_W = 16, TD = 4, SS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    servo_gait_seq_if #(.NCH(NCH), .NKF(NKF), .PW_W(PW_W)) bus();

    servo_gait_seq #(
        .NCH(NCH), .NKF(NKF), .PW_W(PW_W), .TICK_DIV(TD), .STEP_SHIFT(SS),
        .PW_MIN(500), .PW_MAX(2500), .PW_NEUTRAL(1500)
    ) dut (
        .CLK(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [NCH*PW_W-1:0] pl;
        logic                run;
        logic [1:0]          seg;
        logic                dn;
        logic [NCH-1:0]      en;
        logic                tk;
    } exp_t;

    exp_t q[$];
    exp_t e, me;
    int   kfm [NKF][NCH];
    int   outv [NCH];
    bit   m_run, m_en, m_dn, m_tk;
    int   cnt, pos, seg, mk, ms;
    int   n_chk = 0, n_pass = 0;
    bit   armed = 0, fin_req = 0;
    int   log0[$];
    int   t2 [13] = '{1000, 1000, 1001, 1002, 1003, 1002, 1001, 1000, 1000, 1000, 1000, 1000, 1000};

    function automatic int fdiv(int a, int b);
        return a >= 0 ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int interp(int kk, int s, int c);
        int n, v;
        n = (kk + 1) % NKF;
        v = kfm[kk][c] + fdiv((kfm[n][c] - kfm[kk][c]) * s, 1 << SS);
        return v < 500 ? 500 : v > 2500 ? 2500 : v;
    endfunction

    // playback is tracked as a tick position: keyframe = pos/2^SS, step = pos mod 2^SS
    task automatic model_step();
        m_dn = 0;
        m_tk = 0;
        if (rst) begin
            for (int i = 0; i < NKF; i++) for (int c = 0; c < NCH; c++) kfm[i][c] = 1500;
            for (int c = 0; c < NCH; c++) outv[c] = 1500;
            m_run = 0; m_en = 0; cnt = 0; pos = 0; seg = 0;
        end else begin
            if (bus.stop) m_run = 0;
            else if (bus.start) begin
                m_run = 1; pos = 0; cnt = 0; seg = 0; m_en = 1;
            end else if (m_run && !bus.hold) begin
                cnt = cnt + 1;
                if (cnt == TD) begin
                    cnt = 0;
                    m_tk = 1;
                    mk = (pos >> SS) % NKF;
                    ms = pos % (1 << SS);
                    for (int c = 0; c < NCH; c++) outv[c] = interp(mk, ms, c);
                    if (mk == NKF - 1 && ms == 0 && !bus.loop_en) begin
                        m_dn = 1;
                        m_run = 0;
                    end else begin
                        pos = pos + 1;
                        seg = (pos >> SS) % NKF;
                    end
                end
            end
            if (bus.kf_wr_en && int'(bus.kf_wr_ch) < NCH)
                kfm[bus.kf_wr_idx][bus.kf_wr_ch] = int'(bus.kf_wr_data);
        end
        for (int c = 0; c < NCH; c++) me.pl[c*PW_W +: PW_W] = outv[c][PW_W-1:0];
        me.run = m_run;
        me.seg = seg[1:0];
        me.dn  = m_dn;
        me.en  = {NCH{m_en}};
        me.tk  = m_tk;
        q.push_back(me);
    endtask

    always @(posedge clk) model_step();

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        n_chk = n_chk + 1;
        if (act === expv) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pul_len", 64'(bus.pul_len), 64'(e.pl));
            chk("running", 64'(bus.running), 64'(e.run));
            chk("seg_idx", 64'(bus.seg_idx), 64'(e.seg));
            chk("done", 64'(bus.done), 64'(e.dn));
            chk("servo_en", 64'(bus.servo_en), 64'(e.en));
            if (!armed) log0.delete();
            else if (e.tk) log0.push_back(int'(bus.pul_len[PW_W-1:0]));
            if (armed && e.dn) begin
                chk("t2_ticks", 64'(log0.size()), 64'd13);
                foreach (t2[i])
                    if (i < log0.size()) chk($sformatf("t2_ch0[%0d]", i), 64'(log0[i]), 64'(t2[i]));
            end
        end
        if (fin_req) begin
            chk("drain", 64'(q.size()), 64'd0);
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic wr(input int idx, input int ch, input int d);
        bus.kf_wr_en   = 1'b1;
        bus.kf_wr_idx  = 2'(idx);
        bus.kf_wr_ch   = 2'(ch);
        bus.kf_wr_data = 16'(d);
        cyc(1);
        bus.kf_wr_en = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.hold = 0; bus.loop_en = 0;
        bus.kf_wr_en = 0; bus.kf_wr_idx = 0; bus.kf_wr_ch = 0; bus.kf_wr_data = 0;
        @(negedge clk);
        cyc(1);
        rst = 1'b0;
        cyc(3);
        pulse_start();
        cyc(60);
        wr(0, 0, 1000); wr(1, 0, 1003); wr(2, 0, 1000); wr(3, 0, 1000);
        bus.loop_en = 1'b0;
        armed = 1'b1;
        pulse_start();
        cyc(60);
        armed = 1'b0;
        wr(0, 1, 1500); wr(1, 1, 1300);
        bus.loop_en = 1'b1;
        pulse_start();
        cyc(80);
        wr(0, 2, 3000); wr(1, 2, 100);
        pulse_start();
        cyc(40);
        pulse_start();
        cyc(8);
        bus.hold = 1'b1;
        cyc(10);
        bus.hold = 1'b0;
        cyc(12);
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        cyc(10);
        pulse_start();
        cyc(10);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(5);
        repeat (3000) begin
            rst = $urandom_range(0, 299) == 0;
            bus.start = $urandom_range(0, 39) == 0;
            bus.stop = $urandom_range(0, 79) == 0;
            if ($urandom_range(0, 29) == 0) bus.hold = ~bus.hold;
            if ($urandom_range(0, 99) == 0) bus.loop_en = ~bus.loop_en;
            bus.kf_wr_en = $urandom_range(0, 5) == 0;
            bus.kf_wr_idx = 2'($urandom_range(0, 3));
            bus.kf_wr_ch = 2'($urandom_range(0, 3));
            bus.kf_wr_data = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(300, 2700));
            cyc(1);
        end
        rst = 0; bus.start = 0; bus.stop = 0; bus.kf_wr_en = 0;
        cyc(2);
        fin_req = 1'b1;
        cyc(5);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1);
    end
endmodule
